// File: rtl/ysyx_step_ctrl.sv
// Multi-cycle fetch/execute sequencer for the NPC core: fetches one instruction per step,
// gates the regfile write strobe, commits next_pc and halts on ebreak/illegal/misalign/timeout.
module ysyx_step_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [31:0]      imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  output logic [31:0]      inst,
  input  logic             dec_rf_wr_en,
  input  logic             dec_is_ebreak,
  input  logic             dec_illegal,
  input  logic [31:0]      next_pc,
  output logic             rf_wr_en,
  output logic [31:0]      pc,
  output logic             halt,
  output logic [1:0]       halt_code,
  output logic [CNT_W-1:0] instret
);

  localparam logic [31:0]     NopInst    = 32'h0000_0013;
  localparam int unsigned     WaitW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam bit              UseTimeout = (TIMEOUT != 0);
  // Last WAIT cycle index before timing out; unused when the timeout is disabled.
  localparam logic [WaitW-1:0] WaitLast  = WaitW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  localparam logic [1:0] CodeNone    = 2'd0;
  localparam logic [1:0] CodeEbreak  = 2'd1;
  localparam logic [1:0] CodeIllegal = 2'd2;
  localparam logic [1:0] CodeTimeout = 2'd3;

  typedef enum logic [1:0] {StFetch, StWait, StExec, StHalt} state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        inst_q, inst_d;
  logic [1:0]         code_q, code_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic               req_valid;
  logic               wr_strobe;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    code_d    = code_q;
    instret_d = instret_q;
    wait_d    = wait_q;
    req_valid = 1'b0;
    wr_strobe = 1'b0;
    unique case (state_q)
      StFetch: begin
        req_valid = 1'b1;
        if (imem_req_ready) begin
          state_d = StWait;
          wait_d  = '0;
        end
      end
      StWait: begin
        // A response in the final WAIT cycle beats the timeout.
        if (imem_rsp_valid) begin
          inst_d  = imem_rsp_data;
          state_d = StExec;
        end else begin
          wait_d = wait_q + 1'b1;
          if (UseTimeout && (wait_q == WaitLast)) begin
            code_d  = CodeTimeout;
            state_d = StHalt;
          end
        end
      end
      StExec: begin
        if (dec_is_ebreak) begin
          code_d  = CodeEbreak;
          state_d = StHalt;
        end else if (dec_illegal || (next_pc[1:0] != 2'b00)) begin
          code_d  = CodeIllegal;
          state_d = StHalt;
        end else begin
          wr_strobe = dec_rf_wr_en;
          pc_d      = next_pc;
          instret_d = instret_q + 1'b1;
          state_d   = StFetch;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      inst_q    <= NopInst;
      code_q    <= CodeNone;
      instret_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      code_q    <= code_d;
      instret_q <= instret_d;
      wait_q    <= wait_d;
    end
  end

  // Strobes are forced low while reset is held, whatever state the register holds.
  assign imem_req_valid = req_valid && !rst;
  assign rf_wr_en       = wr_strobe && !rst;
  assign imem_req_addr  = pc_q;
  assign pc             = pc_q;
  assign inst           = inst_q;
  assign halt           = (state_q == StHalt);
  assign halt_code      = code_q;
  assign instret        = instret_q;

endmodule
